// File: rtl/mem_access_unit_if.sv
// Request/response and DataMemory pin bundle for mem_access_unit.
// slave = the unit itself, master = the MEM stage plus memory side.
interface mem_access_unit_if #(
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       resp_rdata;
  logic [ADDR_W-3:0] mem_address;
  logic [31:0]       mem_write_data;
  logic [31:0]       mem_read_data;
  logic              mem_read;
  logic              mem_write;

  modport slave (
    input  req_valid, req_write, req_size,
    input  req_signed, req_addr, req_wdata,
    input  mem_read_data,
    output req_ready, resp_valid, resp_err,
    output resp_rdata, mem_address,
    output mem_write_data, mem_read, mem_write
  );

  modport master (
    output req_valid, req_write, req_size,
    output req_signed, req_addr, req_wdata,
    output mem_read_data,
    input  req_ready, resp_valid, resp_err,
    input  resp_rdata, mem_address,
    input  mem_write_data, mem_read, mem_write
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store initiator for a posedge-read, negedge-write word memory.
// Sub-word stores go through read-modify-write; loads are lane-extended.
module mem_access_unit #(
  parameter int ADDR_W = 8
) (
  input  logic clk,
  input  logic rst,
  mem_access_unit_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, RD, CAP, WR, ERR
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        lane_q, lane_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic              write_q, write_d;
  logic [15:0]       wdata_q, wdata_d;

  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic [ADDR_W-3:0] mem_address_q, mem_address_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;

  logic        accept;
  logic        req_bad;
  logic [4:0]  sh;
  logic [31:0] rd_word;
  logic [31:0] load_val;
  logic [31:0] merged;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  assign accept = bus.req_valid & req_ready_q;

  always_comb begin
    req_bad = 1'b0;
    unique case (bus.req_size)
      2'b00: req_bad = 1'b0;
      2'b01: req_bad = bus.req_addr[0];
      2'b10: req_bad = |bus.req_addr[1:0];
      default: req_bad = 1'b1;
    endcase
  end

  // Lane shift, extraction and merge all work from the captured word
  assign rd_word = bus.mem_read_data;
  assign sh      = {lane_q, 3'b000};
  assign ld_b    = 8'(rd_word >> sh);
  assign ld_h    = lane_q[1] ? rd_word[31:16]
                             : rd_word[15:0];

  always_comb begin
    load_val = rd_word;
    merged   = rd_word;
    unique case (size_q)
      2'b00: begin
        load_val = {{24{signed_q & ld_b[7]}}, ld_b};
        merged   = (rd_word & ~(32'h0000_00ff << sh))
                 | ({24'd0, wdata_q[7:0]} << sh);
      end
      2'b01: begin
        load_val = {{16{signed_q & ld_h[15]}}, ld_h};
        merged   = (rd_word & ~(32'h0000_ffff << sh))
                 | ({16'd0, wdata_q} << sh);
      end
      default: begin
        load_val = rd_word;
        merged   = rd_word;
      end
    endcase
  end

  always_comb begin
    state_d       = state_q;
    lane_d        = lane_q;
    size_d        = size_q;
    signed_d      = signed_q;
    write_d       = write_q;
    wdata_d       = wdata_q;
    req_ready_d   = req_ready_q;
    resp_valid_d  = 1'b0;
    resp_err_d    = 1'b0;
    resp_rdata_d  = 32'd0;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (accept) begin
          lane_d        = bus.req_addr[1:0];
          size_d        = bus.req_size;
          signed_d      = bus.req_signed;
          write_d       = bus.req_write;
          wdata_d       = bus.req_wdata[15:0];
          mem_address_d = bus.req_addr[ADDR_W-1:2];
          req_ready_d   = 1'b0;
          if (req_bad) begin
            state_d = ERR;
          end else if (bus.req_write &&
                       bus.req_size == 2'b10) begin
            state_d     = WR;
            mem_write_d = 1'b1;
            mem_wdata_d = bus.req_wdata;
          end else begin
            state_d    = RD;
            mem_read_d = 1'b1;
          end
        end
      end
      RD: state_d = CAP;
      CAP: begin
        if (write_q) begin
          state_d     = WR;
          mem_write_d = 1'b1;
          mem_wdata_d = merged;
        end else begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_val;
          req_ready_d  = 1'b1;
        end
      end
      WR: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
        req_ready_d  = 1'b1;
      end
      ERR: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b1;
        req_ready_d  = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      lane_q        <= 2'd0;
      size_q        <= 2'd0;
      signed_q      <= 1'b0;
      write_q       <= 1'b0;
      wdata_q       <= 16'd0;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_rdata_q  <= 32'd0;
      mem_address_q <= '0;
      mem_wdata_q   <= 32'd0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      lane_q        <= lane_d;
      size_q        <= size_d;
      signed_q      <= signed_d;
      write_q       <= write_d;
      wdata_q       <= wdata_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_err_q    <= resp_err_d;
      resp_rdata_q  <= resp_rdata_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
    end
  end

  assign bus.req_ready      = req_ready_q;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_err       = resp_err_q;
  assign bus.resp_rdata     = resp_rdata_q;
  assign bus.mem_address    = mem_address_q;
  assign bus.mem_write_data = mem_wdata_q;
  assign bus.mem_read       = mem_read_q;
  assign bus.mem_write      = mem_write_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit against a 64-word
// posedge-read / negedge-write memory model.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad   = 0;

  mem_access_unit_if #(.ADDR_W(8)) bus ();

  mem_access_unit #(.ADDR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [64];

  always @(posedge clk)
    if (bus.mem_read) bus.mem_read_data <= mem[bus.mem_address];

  always @(negedge clk)
    if (bus.mem_write) mem[bus.mem_address] <= bus.mem_write_data;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  int          lat, rdc, wrc;
  logic        err, both;
  logic [31:0] rdat, wds;
  logic [5:0]  adr;

  task automatic run_req(input logic w, input logic [1:0] sz,
                         input logic sg, input logic [7:0] a,
                         input logic [31:0] wd);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 99; err = 1'b0; rdat = 32'd0;
    rdc = 0; wrc = 0; wds = 32'd0; both = 1'b0;
    adr = bus.mem_address;
    for (int i = 1; i <= 8; i++) begin
      rdc += int'(bus.mem_read);
      wrc += int'(bus.mem_write);
      if (bus.mem_write) wds = bus.mem_write_data;
      if (bus.mem_read & bus.mem_write) both = 1'b1;
      @(posedge clk);
      #1;
      if (bus.resp_valid) begin
        lat  = i;
        err  = bus.resp_err;
        rdat = bus.resp_rdata;
        break;
      end
    end
  endtask

  initial begin
    bus.req_valid     = 1'b0;
    bus.req_write     = 1'b0;
    bus.req_size      = 2'b00;
    bus.req_signed    = 1'b0;
    bus.req_addr      = 8'd0;
    bus.req_wdata     = 32'd0;
    bus.mem_read_data = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_rd_wr", 32'({bus.mem_read, bus.mem_write}), 32'd0);
    chk("rst_addr", 32'(bus.mem_address), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // word store then word load
    run_req(1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF);
    chk("ws_addr", 32'(adr), 32'd4);
    chk("ws_lat", 32'(lat), 32'd1);
    chk("ws_wcnt", 32'(wrc), 32'd1);
    chk("ws_rcnt", 32'(rdc), 32'd0);
    chk("ws_data", wds, 32'hDEADBEEF);
    chk("ws_mem", mem[4], 32'hDEADBEEF);
    run_req(1'b0, 2'b10, 1'b0, 8'h10, 32'd0);
    chk("wl_lat", 32'(lat), 32'd2);
    chk("wl_data", rdat, 32'hDEADBEEF);
    chk("wl_rcnt", 32'(rdc), 32'd1);

    // byte store read-modify-write
    run_req(1'b1, 2'b10, 1'b0, 8'h20, 32'h11223344);
    run_req(1'b1, 2'b00, 1'b0, 8'h21, 32'h000000AA);
    chk("bs_lat", 32'(lat), 32'd3);
    chk("bs_wcnt", 32'(wrc), 32'd1);
    chk("bs_rcnt", 32'(rdc), 32'd1);
    chk("bs_data", wds, 32'h1122AA44);
    chk("bs_rsp", rdat, 32'd0);
    chk("bs_both", 32'(both), 32'd0);
    run_req(1'b0, 2'b10, 1'b0, 8'h20, 32'd0);
    chk("bs_load", rdat, 32'h1122AA44);

    // lane extraction and extension
    run_req(1'b1, 2'b10, 1'b0, 8'h30, 32'h80FF7F01);
    run_req(1'b0, 2'b00, 1'b1, 8'h33, 32'd0);
    chk("lb_s33", rdat, 32'hFFFFFF80);
    chk("lb_err", 32'(err), 32'd0);
    run_req(1'b0, 2'b00, 1'b0, 8'h33, 32'd0);
    chk("lbu_33", rdat, 32'h00000080);
    run_req(1'b0, 2'b01, 1'b1, 8'h30, 32'd0);
    chk("lh_s30", rdat, 32'h00007F01);
    run_req(1'b0, 2'b01, 1'b1, 8'h32, 32'd0);
    chk("lh_s32", rdat, 32'hFFFF80FF);
    run_req(1'b0, 2'b01, 1'b0, 8'h32, 32'd0);
    chk("lhu_32", rdat, 32'h000080FF);

    // top of address space, half store lane 1
    run_req(1'b1, 2'b10, 1'b0, 8'hFC, 32'h7C112233);
    run_req(1'b0, 2'b00, 1'b1, 8'hFF, 32'd0);
    chk("top_addr", 32'(adr), 32'd63);
    chk("top_byte", rdat, 32'h0000007C);
    run_req(1'b1, 2'b01, 1'b0, 8'hFE, 32'hFFFF5A5A);
    chk("hs_data", wds, 32'h5A5A2233);
    chk("hs_mem", mem[63], 32'h5A5A2233);

    // error requests
    run_req(1'b1, 2'b10, 1'b0, 8'h04, 32'h0BADC0DE);
    run_req(1'b1, 2'b01, 1'b0, 8'h05, 32'h0000FFFF);
    chk("eh_lat", 32'(lat), 32'd1);
    chk("eh_err", 32'(err), 32'd1);
    chk("eh_rdwr", 32'(rdc + wrc), 32'd0);
    run_req(1'b0, 2'b10, 1'b0, 8'h06, 32'd0);
    chk("ew_lat", 32'(lat), 32'd1);
    chk("ew_err", 32'(err), 32'd1);
    chk("ew_rdwr", 32'(rdc + wrc), 32'd0);
    chk("ew_rsp", rdat, 32'd0);
    run_req(1'b1, 2'b11, 1'b0, 8'h04, 32'h12345678);
    chk("es_lat", 32'(lat), 32'd1);
    chk("es_err", 32'(err), 32'd1);
    chk("es_rdwr", 32'(rdc + wrc), 32'd0);
    chk("err_mem", mem[1], 32'h0BADC0DE);

    // back-to-back: load 0x00 then word store 0x04
    run_req(1'b1, 2'b10, 1'b0, 8'h00, 32'hCAFEF00D);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'b10;
    bus.req_addr   = 8'h00;
    @(posedge clk);
    #1;
    bus.req_write = 1'b1;
    bus.req_addr  = 8'h04;
    bus.req_wdata = 32'h00000055;
    chk("bb_rd_rdy", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("bb_cap_rdy", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("bb_vld1", 32'(bus.resp_valid), 32'd1);
    chk("bb_rdy1", 32'(bus.req_ready), 32'd1);
    chk("bb_data1", bus.resp_rdata, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("bb_acc2", 32'({bus.resp_valid, bus.mem_write}), 32'd1);
    chk("bb_wr_rdy", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("bb_vld2", 32'({bus.resp_valid, bus.mem_write}), 32'd2);
    chk("bb_mem", mem[1], 32'h00000055);

    // reset during CAP of a byte store
    run_req(1'b1, 2'b10, 1'b0, 8'h50, 32'hA5A5A5A5);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_size  = 2'b00;
    bus.req_addr  = 8'h51;
    bus.req_wdata = 32'h00000000;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rm_ready", 32'(bus.req_ready), 32'd1);
    chk("rm_outs", 32'({bus.resp_valid, bus.resp_err,
                        bus.mem_read, bus.mem_write}), 32'd0);
    chk("rm_addr", 32'(bus.mem_address), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    lat = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      lat += int'(bus.resp_valid) + int'(bus.mem_write);
    end
    chk("rm_quiet", 32'(lat), 32'd0);
    chk("rm_mem", mem[20], 32'hA5A5A5A5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
